sap_control_sequencer: RTL

//  SAP-1 controller-sequencer: six-state ring counter (T1..T6) plus instruction decoder.

---
 rtl/sap_control_sequencer_if.sv | 22 ++
 rtl/sap_control_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer_if.sv
// Control-sequencer bus: IR opcode in, control word, ring state and halt flag out.
// The sequencer drives through the master modport; the datapath/IR side uses slave.
interface sap_control_sequencer_if;
  logic [3:0]  instruction;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halted;

  modport master (
    input  instruction,
    output control_word,
    output t_state,
    output halted
  );

  modport slave (
    output instruction,
    input  control_word,
    input  t_state,
    input  halted
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter plus microinstruction decoder.
// Define SAP_VARCYCLE_EN to skip idle execute states (variable machine cycle).
module sap_control_sequencer #(
  parameter logic [3:0] OPC_LDA = 4'b0000,
  parameter logic [3:0] OPC_ADD = 4'b0001,
  parameter logic [3:0] OPC_SUB = 4'b0010,
  parameter logic [3:0] OPC_OUT = 4'b1110,
  parameter logic [3:0] OPC_HLT = 4'b1111
) (
  input  logic                          clock,
  input  logic                          reset,
  sap_control_sequencer_if.master       bus
);

  // Word layout: {Cp,Ep,Lm_n,Ce,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam logic [11:0] WordIdle   = 12'h2E3;
  localparam logic [11:0] WordFetch1 = 12'h4E3;
  localparam logic [11:0] WordFetch2 = 12'hAE3;
  localparam logic [11:0] WordFetch3 = 12'h363;
  localparam logic [11:0] WordIrToMar = 12'h0A3;
  localparam logic [11:0] WordLdaT5  = 12'h3C3;
  localparam logic [11:0] WordAddT5  = 12'h3E1;
  localparam logic [11:0] WordAddT6  = 12'h2C7;
  localparam logic [11:0] WordSubT5  = 12'h3E9;
  localparam logic [11:0] WordSubT6  = 12'h2CF;
  localparam logic [11:0] WordOutT4  = 12'h2F2;

  typedef enum logic [5:0] {
    StT1 = 6'b000001,
    StT2 = 6'b000010,
    StT3 = 6'b000100,
    StT4 = 6'b001000,
    StT5 = 6'b010000,
    StT6 = 6'b100000
  } t_state_e;

  t_state_e state_q, state_d;
  logic     halted_q, halted_d;
  logic     is_hlt;

  assign is_hlt = (bus.instruction == OPC_HLT);

`ifdef SAP_VARCYCLE_EN
  logic is_lda, is_out, is_known;

  assign is_lda   = (bus.instruction == OPC_LDA);
  assign is_out   = (bus.instruction == OPC_OUT);
  assign is_known = (bus.instruction == OPC_LDA) || (bus.instruction == OPC_ADD) ||
                    (bus.instruction == OPC_SUB) || (bus.instruction == OPC_OUT) ||
                    (bus.instruction == OPC_HLT);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StT1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Ring advance; once halted the ring holds at T5 until reset.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      unique case (state_q)
        StT1: state_d = StT2;
        StT2: state_d = StT3;
        StT3: begin
          state_d = StT4;
`ifdef SAP_VARCYCLE_EN
          if (!is_known) state_d = StT1;
`endif
        end
        StT4: begin
          state_d = StT5;
          if (is_hlt) begin
            halted_d = 1'b1;
`ifdef SAP_VARCYCLE_EN
          end else if (is_out) begin
            state_d = StT1;
`endif
          end
        end
        StT5: begin
          state_d = StT6;
`ifdef SAP_VARCYCLE_EN
          if (is_lda) state_d = StT1;
`endif
        end
        StT6: state_d = StT1;
        default: state_d = StT1;
      endcase
    end
  end

  // Decode: purely combinational from registered state and the stable IR nibble.
  always_comb begin
    bus.control_word = WordIdle;
    if (!halted_q) begin
      unique case (state_q)
        StT1: bus.control_word = WordFetch1;
        StT2: bus.control_word = WordFetch2;
        StT3: bus.control_word = WordFetch3;
        StT4: begin
          if ((bus.instruction == OPC_LDA) || (bus.instruction == OPC_ADD) ||
              (bus.instruction == OPC_SUB)) begin
            bus.control_word = WordIrToMar;
          end else if (bus.instruction == OPC_OUT) begin
            bus.control_word = WordOutT4;
          end
        end
        StT5: begin
          if (bus.instruction == OPC_LDA) begin
            bus.control_word = WordLdaT5;
          end else if (bus.instruction == OPC_ADD) begin
            bus.control_word = WordAddT5;
          end else if (bus.instruction == OPC_SUB) begin
            bus.control_word = WordSubT5;
          end
        end
        StT6: begin
          if (bus.instruction == OPC_ADD) begin
            bus.control_word = WordAddT6;
          end else if (bus.instruction == OPC_SUB) begin
            bus.control_word = WordSubT6;
          end
        end
        default: bus.control_word = WordIdle;
      endcase
    end
  end

  assign bus.t_state = state_q;
  assign bus.halted  = halted_q;

endmodule
